pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter MEM_WAIT, default 2, SHALL set the number of wait cycles between the exception-vector read request and the PC load (legal range 1..15).
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port instr_valid  input  1  SHALL mark a decoded instruction ready for PC sequencing.
REQ-005 Port kind  input  2  SHALL give the instruction class: 0 SEQ, 1 BRANCH, 2 JUMP, 3 reserved (treated as SEQ).
REQ-006 Port cond_taken  input  1  SHALL be the ALU branch-condition result, valid during RESOLVE.
REQ-007 Port exc_req  input  1  SHALL request an exception (opcode invalid, overflow or divide-by-zero).
REQ-008 Port exc_code  input  2  SHALL identify the exception: 0 opcode, 1 overflow, 2 div0, 3 treated as 2.
REQ-009 Port pc_src  output  2  SHALL drive the PC source-mux select: 0 PC+4, 1 branch target, 2 jump target, 3 exception vector.
REQ-010 Port pc_write  output  1  SHALL enable the PC register load.
REQ-011 Port epc_write  output  1  SHALL enable the EPC register load.
REQ-012 Port vec_rd  output  1  SHALL request a memory read of the exception vector.
REQ-013 Port vec_addr  output  8  SHALL give the vector address, 0xFD + exc_code (saturated at 0xFF).
REQ-014 Port busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-015 Port done  output  1  SHALL pulse for one cycle when a PC update sequence completes.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, RESOLVE, EXC_RD, EXC_WAIT and EXC_LOAD; all outputs SHALL be Moore-decoded from the state and the latched registers.
REQ-017 In IDLE, instr_valid=1 with exc_req=0 SHALL latch kind and move to FETCH; instr_valid SHALL be ignored while busy=1.
REQ-018 FETCH SHALL last one cycle with pc_src=0 and pc_write=1, then move to RESOLVE.
REQ-019 RESOLVE SHALL sample cond_taken and drive: BRANCH and taken -> pc_src=1, pc_write=1; JUMP -> pc_src=2, pc_write=1; otherwise pc_write=0. It SHALL assert done=1 and return to IDLE.
REQ-020 Whenever pc_write=0, pc_src SHALL be 0.
REQ-021 exc_req=1 in IDLE, FETCH or RESOLVE SHALL override all other transitions: the FSM moves to EXC_RD, latches exc_code, and the normal pc_write of that cycle is still issued.
REQ-022 EXC_RD SHALL last one cycle with epc_write=1, vec_rd=1 and vec_addr valid, and SHALL load a wait counter with MEM_WAIT.
REQ-023 EXC_WAIT SHALL hold vec_addr, decrement the counter each cycle, and move to EXC_LOAD when the counter reaches 1.
REQ-024 EXC_LOAD SHALL drive pc_src=3, pc_write=1 and done=1, then return to IDLE.
REQ-025 exc_req SHALL be ignored in the EXC_* states; no nesting is allowed.
REQ-026 Latency: instr_valid accepted at cycle N -> FETCH at N+1 and RESOLVE/done at N+2; exc_req accepted at cycle N -> EXC_LOAD at N+2+MEM_WAIT-1.

Reset
REQ-027 reset_n=0 SHALL force the state to IDLE, clear the counter and the latched kind/code, and drive pc_src=0, pc_write=0, epc_write=0, vec_rd=0, vec_addr=0, busy=0 and done=0 immediately, including mid-sequence.
REQ-028 After reset release, the first rising edge SHALL evaluate from IDLE.

Structure
REQ-029 The pc_src encodings, the kind encodings, the FSM state enum and VEC_BASE=0xFD SHALL live in the shared package cpu_pkg.
REQ-030 No sub-module SHALL be used: the counter is inline, and the PC source mux remains in the datapath, driven by pc_src.

Verification
REQ-031 SEQ: instr_valid, kind=0 -> pc_write=1 with pc_src=0 at N+1; pc_write=0 and done=1 at N+2.
REQ-032 BRANCH: kind=1, cond_taken=1 -> pc_src=1 and pc_write=1 at N+2; with cond_taken=0 -> pc_write=0 and pc_src=0.
REQ-033 JUMP: kind=2 -> pc_src=2 and pc_write=1 at N+2; instr_valid held high in FETCH is ignored.
REQ-034 Overflow in RESOLVE: exc_code=1 -> EXC_RD with vec_addr=0xFE and epc_write=1; with MEM_WAIT=2, pc_src=3, pc_write=1 and done=1 two cycles after EXC_RD.
REQ-035 exc_code=3 -> vec_addr=0xFF; exc_req during EXC_WAIT -> ignored, and the sequence completes once.
REQ-036 reset_n asserted low mid-EXC_WAIT -> all outputs 0 asynchronously; after release, a fresh instruction sequences normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the PC sequencing control path: mux selects,
// instruction classes, sequencer states and exception vector base.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_EXC    = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        K_SEQ    = 2'd0,
        K_BRANCH = 2'd1,
        K_JUMP   = 2'd2,
        K_RSVD   = 2'd3
    } kind_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_RESOLVE  = 3'd2,
        S_EXC_RD   = 3'd3,
        S_EXC_WAIT = 3'd4,
        S_EXC_LOAD = 3'd5
    } state_e;

    localparam logic [7:0] VEC_BASE = 8'hFD;

    // Code 3 aliases div0, which also keeps the sum from wrapping past 0xFF.
    function automatic logic [7:0] vec_addr_f(input logic [1:0] code);
        logic [1:0] c;
        c = (code == 2'd3) ? 2'd2 : code;
        return VEC_BASE + {6'd0, c};
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// PC update sequencer: steps a decoded instruction through fetch/resolve,
// or runs the exception path (EPC save, vector read, wait, PC load).
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       instr_valid,
    input  logic [1:0] kind,
    input  logic       cond_taken,
    input  logic       exc_req,
    input  logic [1:0] exc_code,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       epc_write,
    output logic       vec_rd,
    output logic [7:0] vec_addr,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    kind_e      kind_q, kind_d;
    logic [1:0] code_q, code_d;
    logic [3:0] cnt_q, cnt_d;
    pc_src_e    src;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_SEQ;
            code_q  <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (instr_valid) begin
                kind_d  = kind_e'(kind);
                state_d = S_FETCH;
            end
            S_FETCH:   state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_IDLE;
            S_EXC_RD: begin
                cnt_d   = 4'(MEM_WAIT);
                state_d = (MEM_WAIT <= 1) ? S_EXC_LOAD : S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd2) state_d = S_EXC_LOAD;
            end
            S_EXC_LOAD: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // Exceptions preempt the normal flow but never nest.
        if (exc_req && (state_q == S_IDLE || state_q == S_FETCH || state_q == S_RESOLVE)) begin
            state_d = S_EXC_RD;
            code_d  = exc_code;
        end
    end

    always_comb begin
        src       = PC_SEQ;
        pc_write  = 1'b0;
        epc_write = 1'b0;
        vec_rd    = 1'b0;
        vec_addr  = 8'd0;
        done      = 1'b0;
        case (state_q)
            S_FETCH: pc_write = 1'b1;
            S_RESOLVE: begin
                done = 1'b1;
                if (kind_q == K_BRANCH && cond_taken) begin
                    src      = PC_BRANCH;
                    pc_write = 1'b1;
                end else if (kind_q == K_JUMP) begin
                    src      = PC_JUMP;
                    pc_write = 1'b1;
                end
            end
            S_EXC_RD: begin
                epc_write = 1'b1;
                vec_rd    = 1'b1;
                vec_addr  = vec_addr_f(code_q);
            end
            S_EXC_WAIT: vec_addr = vec_addr_f(code_q);
            S_EXC_LOAD: begin
                src      = PC_EXC;
                pc_write = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_src = src;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, directed exception/reset sequences,
// then random traffic against a schedule-queue reference model.
module tb_pc_sequencer;

    localparam int MW = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       instr_valid, cond_taken, exc_req;
    logic [1:0] kind, exc_code, pc_src;
    logic       pc_write, epc_write, vec_rd, busy, done;
    logic [7:0] vec_addr;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .kind(kind),
        .cond_taken(cond_taken), .exc_req(exc_req), .exc_code(exc_code),
        .pc_src(pc_src), .pc_write(pc_write), .epc_write(epc_write),
        .vec_rd(vec_rd), .vec_addr(vec_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] src;
        logic       wr, epc, vrd, bsy, dn;
    } outs_t;

    function automatic outs_t mk(input int s, input bit w, input bit e, input bit v,
                                 input bit b, input bit d);
        outs_t o;
        o.src = 2'(s); o.wr = w; o.epc = e; o.vrd = v; o.bsy = b; o.dn = d;
        return o;
    endfunction

    function automatic outs_t get_outs();
        return {pc_src, pc_write, epc_write, vec_rd, busy, done};
    endfunction

    task automatic check(input string nm, input outs_t exp);
        outs_t g;
        g = get_outs();
        n_tests++;
        if (g !== exp) begin
            n_fail++;
            $display("FAIL %s: got src/wr/epc/vrd/busy/done=%b want %b at %0t", nm, g, exp, $time);
        end
    endtask

    task automatic check_va(input string nm, input logic [7:0] exp);
        n_tests++;
        if (vec_addr !== exp) begin
            n_fail++;
            $display("FAIL %s: vec_addr got %h want %h at %0t", nm, vec_addr, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are read 1 time unit later.
    task automatic step(input bit iv, input int k, input bit c, input bit e, input int ec);
        @(negedge clk);
        instr_valid = iv; kind = 2'(k); cond_taken = c; exc_req = e; exc_code = 2'(ec);
        #1;
    endtask

    function automatic logic [7:0] sat_vec(input logic [1:0] code);
        int a;
        a = 253 + int'(code);
        if (a > 255) a = 255;
        return 8'(a);
    endfunction

    // Reference model: a queue of the cycles still to be played out.
    typedef enum {R_FETCH, R_RES, R_RD, R_WAIT, R_LOAD} rk_e;
    typedef struct {
        rk_e        t;
        logic [1:0] k;
        logic [1:0] code;
    } rec_t;
    rec_t q[$];

    function automatic outs_t model_out(input bit have, input rec_t r, input logic c);
        if (!have) return mk(0, 0, 0, 0, 0, 0);
        case (r.t)
            R_FETCH: return mk(0, 1, 0, 0, 1, 0);
            R_RES: begin
                if (r.k == 2'd1 && c) return mk(1, 1, 0, 0, 1, 1);
                if (r.k == 2'd2)      return mk(2, 1, 0, 0, 1, 1);
                return mk(0, 0, 0, 0, 1, 1);
            end
            R_RD:    return mk(0, 0, 1, 1, 1, 0);
            R_WAIT:  return mk(0, 0, 0, 0, 1, 0);
            default: return mk(3, 1, 0, 0, 1, 1);
        endcase
    endfunction

    typedef struct {
        logic [1:0] k;
        logic       c;
        logic       hold;
        outs_t      res;
    } vec_t;
    vec_t tbl[7];

    outs_t O_IDLE, O_FETCH;

    initial begin
        O_IDLE  = mk(0, 0, 0, 0, 0, 0);
        O_FETCH = mk(0, 1, 0, 0, 1, 0);
        tbl[0] = '{k: 2'd0, c: 1'b0, hold: 1'b0, res: mk(0, 0, 0, 0, 1, 1)};
        tbl[1] = '{k: 2'd1, c: 1'b1, hold: 1'b0, res: mk(1, 1, 0, 0, 1, 1)};
        tbl[2] = '{k: 2'd1, c: 1'b0, hold: 1'b0, res: mk(0, 0, 0, 0, 1, 1)};
        tbl[3] = '{k: 2'd2, c: 1'b0, hold: 1'b1, res: mk(2, 1, 0, 0, 1, 1)};
        tbl[4] = '{k: 2'd3, c: 1'b1, hold: 1'b0, res: mk(0, 0, 0, 0, 1, 1)};
        tbl[5] = '{k: 2'd0, c: 1'b1, hold: 1'b1, res: mk(0, 0, 0, 0, 1, 1)};
        tbl[6] = '{k: 2'd2, c: 1'b1, hold: 1'b1, res: mk(2, 1, 0, 0, 1, 1)};

        reset_n = 1'b0; instr_valid = 0; kind = 0; cond_taken = 0; exc_req = 0; exc_code = 0;
        #12;
        check("reset_outs", O_IDLE);
        check_va("reset_va", 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            step(1, tbl[i].k, tbl[i].c, 0, 0);
            check("tbl_idle", O_IDLE);
            step(tbl[i].hold, tbl[i].k, tbl[i].c, 0, 0);
            check("tbl_fetch", O_FETCH);
            step(0, tbl[i].k, tbl[i].c, 0, 0);
            check("tbl_resolve", tbl[i].res);
            step(0, 0, 0, 0, 0);
            check("tbl_back_idle", O_IDLE);
        end

        // Overflow raised during RESOLVE.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("ovf_fetch", O_FETCH);
        step(0, 0, 0, 1, 1);
        check("ovf_resolve", mk(0, 0, 0, 0, 1, 1));
        step(0, 0, 0, 0, 0);
        check("ovf_rd", mk(0, 0, 1, 1, 1, 0));
        check_va("ovf_rd_va", 8'hFE);
        step(0, 0, 0, 0, 0);
        check("ovf_wait", mk(0, 0, 0, 0, 1, 0));
        check_va("ovf_wait_va", 8'hFE);
        step(0, 0, 0, 0, 0);
        check("ovf_load", mk(3, 1, 0, 0, 1, 1));
        step(0, 0, 0, 0, 0);
        check("ovf_idle", O_IDLE);

        // Code 3 from IDLE, with a second exception attempted during the wait.
        step(1, 2, 0, 1, 3);
        check("c3_idle", O_IDLE);
        step(0, 0, 0, 0, 0);
        check("c3_rd", mk(0, 0, 1, 1, 1, 0));
        check_va("c3_rd_va", 8'hFF);
        step(0, 0, 0, 1, 0);
        check("c3_wait", mk(0, 0, 0, 0, 1, 0));
        check_va("c3_wait_va", 8'hFF);
        step(0, 0, 0, 0, 0);
        check("c3_load", mk(3, 1, 0, 0, 1, 1));
        step(0, 0, 0, 0, 0);
        check("c3_idle_after", O_IDLE);
        step(0, 0, 0, 0, 0);
        check("c3_no_repeat", O_IDLE);

        // Asynchronous reset while waiting on the vector read.
        step(0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_pre_wait", mk(0, 0, 0, 0, 1, 0));
        check_va("rst_pre_va", 8'hFF);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async", O_IDLE);
        check_va("rst_async_va", 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 1, 1, 0, 0);
        check("rst_after_idle", O_IDLE);
        step(0, 1, 1, 0, 0);
        check("rst_after_fetch", O_FETCH);
        step(0, 1, 1, 0, 0);
        check("rst_after_resolve", mk(1, 1, 0, 0, 1, 1));
        step(0, 0, 0, 0, 0);
        check("rst_after_idle2", O_IDLE);

        // Random traffic against the schedule model.
        q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit   have;
            rec_t cur;
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0),
                 int'($urandom_range(0, 3)));
            have = (q.size() > 0);
            cur  = have ? q[0] : '{t: R_FETCH, k: 2'd0, code: 2'd0};
            check("rand_outs", model_out(have, cur, cond_taken));
            if (have && (cur.t == R_RD || cur.t == R_WAIT))
                check_va("rand_va", sat_vec(cur.code));
            if (have) void'(q.pop_front());
            if (exc_req && (!have || cur.t == R_FETCH || cur.t == R_RES)) begin
                q.delete();
                q.push_back('{t: R_RD, k: 2'd0, code: exc_code});
                for (int w = 1; w < MW; w++) q.push_back('{t: R_WAIT, k: 2'd0, code: exc_code});
                q.push_back('{t: R_LOAD, k: 2'd0, code: exc_code});
            end else if (!have && instr_valid) begin
                q.push_back('{t: R_FETCH, k: kind, code: 2'd0});
                q.push_back('{t: R_RES, k: kind, code: 2'd0});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
